// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  audio_pkg : shared types and constants for the audio record/playback path
//  Revision  : 1.0
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 6;
    localparam int ADDR_W   = 18;
    localparam int PEAK_W   = 5;
    localparam int DCNT_W   = 8;

    // Sound-map region shared with playback
    localparam logic [ADDR_W-1:0] SND_REGION_START = 18'd0;
    localparam logic [ADDR_W-1:0] SND_REGION_END   = 18'd137138;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DONE   = 2'd2
    } rec_state_e;

    // Magnitude of a two's-complement sample; the most negative code saturates
    function automatic logic [PEAK_W-1:0] sample_mag(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] neg;
        neg = -s;
        if (!s[SAMPLE_W-1])
            sample_mag = s[PEAK_W-1:0];
        else if (s == {1'b1, {PEAK_W{1'b0}}})
            sample_mag = {PEAK_W{1'b1}};
        else
            sample_mag = neg[PEAK_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_record_if.sv
`default_nettype none
// ============================================================================
//  audio_record_if : codec input FIFO pop and record-RAM write port
//  Revision        : 1.0
// ============================================================================
interface audio_record_if;
    import audio_pkg::*;

    logic                audio_in_available;
    logic [31:0]         left_channel_audio_in;
    logic                read_audio_in;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] mem_data;
    logic                mem_wren;

    modport master (
        input  audio_in_available, left_channel_audio_in,
        output read_audio_in, mem_addr, mem_data, mem_wren
    );

    modport slave (
        output audio_in_available, left_channel_audio_in,
        input  read_audio_in, mem_addr, mem_data, mem_wren
    );

endinterface
`default_nettype wire

// File: rtl/sample_decimator.sv
`default_nettype none
// ============================================================================
//  sample_decimator : flags one of every DECIM pops as accepted
//  Revision         : 1.0
// ============================================================================
module sample_decimator
    import audio_pkg::*;
#(
    parameter int unsigned DECIM = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic pop,
    input  wire logic clear,
    output logic      accept
);

    logic [DCNT_W-1:0] cnt_q;
    logic [DCNT_W-1:0] cnt_d;

    assign accept = pop && (cnt_q == DCNT_W'(DECIM - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || accept)
            cnt_d = '0;
        else if (pop)
            cnt_d = cnt_q + DCNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule
`default_nettype wire

// File: rtl/audio_record.sv
`default_nettype none
// ============================================================================
//  audio_record : captures decimated 6-bit codec samples into the record RAM
//  Revision     : 1.0
// ============================================================================
module audio_record
    import audio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEPTH = 18'd137139,
    parameter int unsigned       DECIM = 4
) (
    input  wire logic           CLOCK_50,
    input  wire logic           reset,
    input  wire logic           record_start,
    input  wire logic           record_stop,
    audio_record_if.master      bus,
    output logic                recording,
    output logic                done,
    output logic [ADDR_W-1:0]   sample_count,
    output logic [PEAK_W-1:0]   peak
);

    rec_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [PEAK_W-1:0]   peak_q, peak_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SAMPLE_W-1:0] data_q, data_d;

    logic                w_dec_pop;
    logic                w_start_go;
    logic                w_accept;
    logic [SAMPLE_W-1:0] w_sample;
    logic [PEAK_W-1:0]   w_mag;

    // A pop in the stop cycle is dropped, so it must not advance the decimator
    assign w_dec_pop  = (state_q == ST_RECORD) && bus.audio_in_available && !record_stop;
    assign w_start_go = (state_q != ST_RECORD) && record_start;
    assign w_sample   = bus.left_channel_audio_in[31:26];
    assign w_mag      = sample_mag(w_sample);

    sample_decimator #(
        .DECIM (DECIM)
    ) u_decim (
        .clk    (CLOCK_50),
        .rst    (reset),
        .pop    (w_dec_pop),
        .clear  (w_start_go),
        .accept (w_accept)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        peak_d   = peak_q;
        wren_d   = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (record_start) begin
                    state_d  = ST_RECORD;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    peak_d   = '0;
                end
            end
            ST_RECORD: begin
                if (record_stop) begin
                    state_d = ST_DONE;
                end else if (w_accept) begin
                    wren_d   = 1'b1;
                    addr_d   = wr_ptr_q;
                    data_d   = w_sample;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    count_d  = count_q + ADDR_W'(1);
                    if (w_mag > peak_q)
                        peak_d = w_mag;
                    // Leaving RECORD on the last address stops any further write
                    if (wr_ptr_q == DEPTH - ADDR_W'(1))
                        state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            peak_q   <= '0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            peak_q   <= peak_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign bus.read_audio_in = bus.audio_in_available;
    assign bus.mem_wren      = wren_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_data      = data_q;
    assign recording         = (state_q == ST_RECORD);
    assign done              = (state_q == ST_DONE);
    assign sample_count      = count_q;
    assign peak              = peak_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_record.sv
`default_nettype none
// ============================================================================
//  tb_audio_record : scoreboard bench, DUT A (DEPTH=8, DECIM=1), DUT B (defaults)
//  Revision        : 1.0
// ============================================================================
module tb_audio_record;

    typedef struct {
        logic [17:0] addr;
        logic [5:0]  data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        avail = 1'b0;
    logic [31:0] sdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int m_rec[2];
    int m_ptr[2];
    int m_cnt[2];
    int m_dec[2];
    int m_dep[2];

    logic        rec_a, done_a, rec_b, done_b;
    logic [17:0] cnt_a, cnt_b;
    logic [4:0]  peak_a, peak_b;

    audio_record_if ifa();
    audio_record_if ifb();

    assign ifa.audio_in_available    = avail;
    assign ifa.left_channel_audio_in = sdata;
    assign ifb.audio_in_available    = avail;
    assign ifb.left_channel_audio_in = sdata;

    audio_record #(.DEPTH(18'd8), .DECIM(1)) dut_a (
        .CLOCK_50(clk), .reset(reset), .record_start(start), .record_stop(stop),
        .bus(ifa.master), .recording(rec_a), .done(done_a),
        .sample_count(cnt_a), .peak(peak_a)
    );

    audio_record dut_b (
        .CLOCK_50(clk), .reset(reset), .record_start(start), .record_stop(stop),
        .bus(ifb.master), .recording(rec_b), .done(done_b),
        .sample_count(cnt_b), .peak(peak_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitors: every write must match the oldest expected write exactly
    always @(negedge clk) begin
        if (ifa.mem_wren === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL wr_a unexpected: addr=%0d data=%0d", ifa.mem_addr, ifa.mem_data);
            end else begin
                ea = qa.pop_front();
                if (ifa.mem_addr !== ea.addr || ifa.mem_data !== ea.data || cyc != ea.cyc) begin
                    errors++;
                    $display("FAIL wr_a got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                             ifa.mem_addr, ifa.mem_data, cyc, ea.addr, ea.data, ea.cyc);
                end
            end
            checks++;
            if (done_a !== (ifa.mem_addr == 18'd7)) begin
                errors++;
                $display("FAIL done_a_at_write addr=%0d done=%b want %b", ifa.mem_addr, done_a, ifa.mem_addr == 18'd7);
            end
        end
        if (ifb.mem_wren === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL wr_b unexpected: addr=%0d data=%0d", ifb.mem_addr, ifb.mem_data);
            end else begin
                eb = qb.pop_front();
                if (ifb.mem_addr !== eb.addr || ifb.mem_data !== eb.data || cyc != eb.cyc) begin
                    errors++;
                    $display("FAIL wr_b got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                             ifb.mem_addr, ifb.mem_data, cyc, eb.addr, eb.data, eb.cyc);
                end
            end
        end
    end

    task automatic model_step(input int k, input logic av, input logic [5:0] s,
                              input logic st, input logic sp);
        exp_t e;
        if (m_rec[k] != 0) begin
            if (sp) begin
                m_rec[k] = 0;
            end else if (av) begin
                m_cnt[k]++;
                if (m_cnt[k] == m_dec[k]) begin
                    m_cnt[k] = 0;
                    e.addr = 18'(m_ptr[k]);
                    e.data = s;
                    e.cyc  = cyc + 1;
                    if (k == 0) qa.push_back(e); else qb.push_back(e);
                    m_ptr[k]++;
                    if (m_ptr[k] == m_dep[k]) m_rec[k] = 0;
                end
            end
        end else if (st) begin
            m_rec[k] = 1;
            m_ptr[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic cyc_drive(input logic av, input logic [5:0] s, input logic st, input logic sp);
        @(negedge clk);
        avail = av;
        sdata = {s, 26'($urandom)};
        start = st;
        stop  = sp;
        model_step(0, av, s, st, sp);
        model_step(1, av, s, st, sp);
        #1;
        checks++;
        if (ifa.read_audio_in !== av || ifb.read_audio_in !== av) begin
            errors++;
            $display("FAIL read_audio_in a=%b b=%b want %b", ifa.read_audio_in, ifb.read_audio_in, av);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_drive(1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic begin_take();
        cyc_drive(1'b0, 6'd0, 1'b0, 1'b1);
        cyc_drive(1'b0, 6'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rec_a, done_a, ifa.mem_wren, ifa.mem_addr, ifa.mem_data, cnt_a, peak_a} !== '0) begin
            errors++;
            $display("FAIL reset_a rec=%b done=%b wren=%b addr=%0d data=%0d cnt=%0d peak=%0d want all 0",
                     rec_a, done_a, ifa.mem_wren, ifa.mem_addr, ifa.mem_data, cnt_a, peak_a);
        end
        checks++;
        if ({rec_b, done_b, ifb.mem_wren, ifb.mem_addr, ifb.mem_data, cnt_b, peak_b} !== '0) begin
            errors++;
            $display("FAIL reset_b rec=%b done=%b wren=%b cnt=%0d peak=%0d want all 0",
                     rec_b, done_b, ifb.mem_wren, cnt_b, peak_b);
        end
        reset = 1'b0;
        // Stop in IDLE is ignored
        cyc_drive(1'b0, 6'd0, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (rec_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL stop_in_idle rec=%b done=%b want 0 0", rec_a, done_a);
        end
    endtask

    task automatic test_decim1();
        begin_take();
        for (int i = 1; i <= 5; i++) cyc_drive(1'b1, 6'(i), 1'b0, 1'b0);
        idle(3);
        checks++;
        if (cnt_a !== 18'd5 || rec_a !== 1'b1) begin
            errors++;
            $display("FAIL decim1_count got cnt=%0d rec=%b want 5 1", cnt_a, rec_a);
        end
        checks++;
        if (cnt_b !== 18'd1) begin
            errors++;
            $display("FAIL decim4_after5 got cnt=%0d want 1", cnt_b);
        end
    endtask

    task automatic test_decim4_and_full();
        begin_take();
        for (int i = 0; i < 12; i++) cyc_drive(1'b1, 6'(i + 10), 1'b0, 1'b0);
        idle(3);
        checks++;
        if (cnt_b !== 18'd3 || rec_b !== 1'b1) begin
            errors++;
            $display("FAIL decim4_count got cnt=%0d rec=%b want 3 1", cnt_b, rec_b);
        end
        checks++;
        if (cnt_a !== 18'd8 || done_a !== 1'b1 || rec_a !== 1'b0) begin
            errors++;
            $display("FAIL full_a got cnt=%0d done=%b rec=%b want 8 1 0", cnt_a, done_a, rec_a);
        end
    endtask

    task automatic test_stop_and_control();
        begin_take();
        for (int i = 0; i < 3; i++) cyc_drive(1'b1, 6'(i + 33), 1'b0, 1'b0);
        cyc_drive(1'b1, 6'h15, 1'b0, 1'b1);
        idle(2);
        checks++;
        if (done_a !== 1'b1 || cnt_a !== 18'd3) begin
            errors++;
            $display("FAIL stop_a got done=%b cnt=%0d want 1 3", done_a, cnt_a);
        end
        checks++;
        if (done_b !== 1'b1 || cnt_b !== 18'd0) begin
            errors++;
            $display("FAIL stop_b got done=%b cnt=%0d want 1 0", done_b, cnt_b);
        end
        cyc_drive(1'b0, 6'd0, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (done_a !== 1'b1 || cnt_a !== 18'd3) begin
            errors++;
            $display("FAIL stop_in_done got done=%b cnt=%0d want 1 3", done_a, cnt_a);
        end
        // Start and stop together from DONE: start wins
        cyc_drive(1'b0, 6'd0, 1'b1, 1'b1);
        idle(1);
        checks++;
        if (rec_a !== 1'b1 || cnt_a !== 18'd0) begin
            errors++;
            $display("FAIL start_stop_done got rec=%b cnt=%0d want 1 0", rec_a, cnt_a);
        end
        cyc_drive(1'b1, 6'd7, 1'b0, 1'b0);
        cyc_drive(1'b0, 6'd0, 1'b1, 1'b0);
        cyc_drive(1'b1, 6'd9, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (cnt_a !== 18'd2 || rec_a !== 1'b1) begin
            errors++;
            $display("FAIL start_in_record got cnt=%0d rec=%b want 2 1", cnt_a, rec_a);
        end
        // Start and stop together in RECORD: stop wins
        cyc_drive(1'b0, 6'd0, 1'b1, 1'b1);
        idle(1);
        checks++;
        if (done_a !== 1'b1 || cnt_a !== 18'd2) begin
            errors++;
            $display("FAIL start_stop_record got done=%b cnt=%0d want 1 2", done_a, cnt_a);
        end
    endtask

    task automatic test_peak();
        begin_take();
        cyc_drive(1'b1, 6'b000011, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (peak_a !== 5'd3) begin
            errors++;
            $display("FAIL peak_first got %0d want 3", peak_a);
        end
        cyc_drive(1'b1, 6'b100000, 1'b0, 1'b0);
        cyc_drive(1'b1, 6'b011110, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (peak_a !== 5'd31 || cnt_a !== 18'd3) begin
            errors++;
            $display("FAIL peak_max got peak=%0d cnt=%0d want 31 3", peak_a, cnt_a);
        end
        begin_take();
        idle(1);
        checks++;
        if (peak_a !== 5'd0 || cnt_a !== 18'd0 || rec_a !== 1'b1) begin
            errors++;
            $display("FAIL peak_clear got peak=%0d cnt=%0d rec=%b want 0 0 1", peak_a, cnt_a, rec_a);
        end
        cyc_drive(1'b1, 6'b111101, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (peak_a !== 5'd3) begin
            errors++;
            $display("FAIL peak_negative got %0d want 3", peak_a);
        end
    endtask

    task automatic test_reset_midtake();
        begin_take();
        cyc_drive(1'b1, 6'd21, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        avail = 1'b0;
        qa.delete();
        qb.delete();
        for (int k = 0; k < 2; k++) begin
            m_rec[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
        end
        @(negedge clk);
        checks++;
        if ({rec_a, done_a, ifa.mem_wren, ifa.mem_addr, ifa.mem_data, cnt_a, peak_a} !== '0) begin
            errors++;
            $display("FAIL midtake_reset rec=%b done=%b wren=%b addr=%0d data=%0d cnt=%0d peak=%0d want all 0",
                     rec_a, done_a, ifa.mem_wren, ifa.mem_addr, ifa.mem_data, cnt_a, peak_a);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(3);
        checks++;
        if (rec_a !== 1'b0 || done_a !== 1'b0 || ifa.mem_wren !== 1'b0 || cnt_a !== 18'd0) begin
            errors++;
            $display("FAIL after_release rec=%b done=%b wren=%b cnt=%0d want 0 0 0 0",
                     rec_a, done_a, ifa.mem_wren, cnt_a);
        end
    endtask

    initial begin
        m_dec[0] = 1;  m_dep[0] = 8;
        m_dec[1] = 4;  m_dep[1] = 137139;
        for (int k = 0; k < 2; k++) begin
            m_rec[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
        end
        test_reset();
        test_decim1();
        test_decim4_and_full();
        test_stop_and_control();
        test_peak();
        test_reset_midtake();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes a=%0d b=%0d want 0 0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
